// File: rtl/bram_stream_master_if.sv
// Request, response and BRAM-port signals of bram_stream_master.
// The master modport is the bram_stream_master side; slave is its environment.
interface bram_stream_master_if #(
  parameter int unsigned ADDR_BITW = 32,
  parameter int unsigned DATA_BITW = 32
);
  logic                   ReqValid_SI;
  logic                   ReqReady_SO;
  logic [ADDR_BITW-1:0]   ReqAddr_DI;
  logic [DATA_BITW/8-1:0] ReqWrEn_DI;
  logic [DATA_BITW-1:0]   ReqWrData_DI;
  logic                   RespValid_SO;
  logic                   RespReady_SI;
  logic [DATA_BITW-1:0]   RespRdData_DO;
  logic                   RespWasWr_SO;
  logic                   BramClk_CO;
  logic                   BramRst_RO;
  logic                   BramEn_SO;
  logic [ADDR_BITW-1:0]   BramAddr_DO;
  logic [DATA_BITW/8-1:0] BramWrEn_DO;
  logic [DATA_BITW-1:0]   BramWrData_DO;
  logic [DATA_BITW-1:0]   BramRdData_DI;

  modport master (
    input  ReqValid_SI, ReqAddr_DI, ReqWrEn_DI, ReqWrData_DI, RespReady_SI, BramRdData_DI,
    output ReqReady_SO, RespValid_SO, RespRdData_DO, RespWasWr_SO,
    output BramClk_CO, BramRst_RO, BramEn_SO, BramAddr_DO, BramWrEn_DO, BramWrData_DO
  );

  modport slave (
    output ReqValid_SI, ReqAddr_DI, ReqWrEn_DI, ReqWrData_DI, RespReady_SI, BramRdData_DI,
    input  ReqReady_SO, RespValid_SO, RespRdData_DO, RespWasWr_SO,
    input  BramClk_CO, BramRst_RO, BramEn_SO, BramAddr_DO, BramWrEn_DO, BramWrData_DO
  );
endinterface

// File: rtl/bram_stream_master.sv
// Valid/ready request stream to BRAM-port master with credit-guarded in-order response FIFO.
// Define BRAM_STREAM_MASTER_WRRESP_EN to make writes produce responses (RespWasWr_SO=1).
module bram_stream_master #(
  parameter int unsigned ADDR_BITW  = 32,
  parameter int unsigned DATA_BITW  = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned RESP_DEPTH = 4
) (
  input logic                  Clk_CI,
  input logic                  Rst_RBI,
  bram_stream_master_if.master bus
);

  localparam int unsigned   PW      = $clog2(RESP_DEPTH);
  localparam int unsigned   CW      = PW + 1;
  localparam int unsigned   STRB    = DATA_BITW / 8;
  localparam logic [CW-1:0] DEPTH_C = CW'(RESP_DEPTH);

  logic                 accept;
  logic                 is_wr;
  logic                 tag_in;
  logic                 push;
  logic                 pop;
  logic                 resp_valid;
  logic [CW-1:0]        cnt;
  logic [RD_LAT-1:0]    tag_vld;
  logic [RD_LAT-1:0]    vld_next;
  logic [PW:0]          wr_ptr;
  logic [PW:0]          rd_ptr;
  logic [DATA_BITW-1:0] fifo_data [RESP_DEPTH];
  logic [ADDR_BITW-1:0] bram_addr;
  logic [STRB-1:0]      bram_wren;
  logic [DATA_BITW-1:0] bram_wdata;
`ifdef BRAM_STREAM_MASTER_WRRESP_EN
  logic [RD_LAT-1:0]    tag_wr;
  logic [RD_LAT-1:0]    wr_next;
  logic                 push_wr;
  logic                 fifo_wr [RESP_DEPTH];
`endif

  assign bus.BramClk_CO = Clk_CI;
  assign bus.BramRst_RO = ~Rst_RBI;

  // Gating with the raw reset makes ready, and with it the BRAM strobe, drop asynchronously.
  assign bus.ReqReady_SO = Rst_RBI && (cnt < DEPTH_C);
  assign accept          = bus.ReqValid_SI && bus.ReqReady_SO;
  assign is_wr           = |bus.ReqWrEn_DI;

  assign bram_addr         = accept ? bus.ReqAddr_DI   : '0;
  assign bram_wren         = accept ? bus.ReqWrEn_DI   : '0;
  assign bram_wdata        = accept ? bus.ReqWrData_DI : '0;
  assign bus.BramEn_SO     = accept;
  assign bus.BramAddr_DO   = bram_addr;
  assign bus.BramWrEn_DO   = bram_wren;
  assign bus.BramWrData_DO = bram_wdata;

`ifdef BRAM_STREAM_MASTER_WRRESP_EN
  assign tag_in = accept;
`else
  assign tag_in = accept && !is_wr;
`endif

  // Tag shift register; bit RD_LAT-1 lines up with the BRAM read data of its request.
  if (RD_LAT > 1) begin : g_shift
    assign vld_next = {tag_vld[RD_LAT-2:0], tag_in};
`ifdef BRAM_STREAM_MASTER_WRRESP_EN
    assign wr_next  = {tag_wr[RD_LAT-2:0], is_wr};
`endif
  end else begin : g_noshift
    assign vld_next = tag_in;
`ifdef BRAM_STREAM_MASTER_WRRESP_EN
    assign wr_next  = is_wr;
`endif
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      tag_vld <= '0;
    end else begin
      tag_vld <= vld_next;
    end
  end

`ifdef BRAM_STREAM_MASTER_WRRESP_EN
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      tag_wr <= '0;
    end else begin
      tag_wr <= wr_next;
    end
  end
  assign push_wr = tag_wr[RD_LAT-1];
`endif

  assign push       = tag_vld[RD_LAT-1];
  assign resp_valid = (wr_ptr != rd_ptr);
  assign pop        = resp_valid && bus.RespReady_SI;

  // Storage needs no reset: the pointers alone decide what is visible.
  always_ff @(posedge Clk_CI) begin
    if (push) begin
`ifdef BRAM_STREAM_MASTER_WRRESP_EN
      fifo_data[wr_ptr[PW-1:0]] <= push_wr ? '0 : bus.BramRdData_DI;
      fifo_wr[wr_ptr[PW-1:0]]   <= push_wr;
`else
      fifo_data[wr_ptr[PW-1:0]] <= bus.BramRdData_DI;
`endif
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Credits track tags in flight plus FIFO occupancy, so a push always finds a free slot.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      cnt <= '0;
    end else if (tag_in != pop) begin
      cnt <= tag_in ? cnt + 1'b1 : cnt - 1'b1;
    end
  end

  assign bus.RespValid_SO  = resp_valid;
  assign bus.RespRdData_DO = resp_valid ? fifo_data[rd_ptr[PW-1:0]] : '0;
`ifdef BRAM_STREAM_MASTER_WRRESP_EN
  assign bus.RespWasWr_SO  = resp_valid && fifo_wr[rd_ptr[PW-1:0]];
`else
  assign bus.RespWasWr_SO  = 1'b0;
`endif

endmodule

// File: tb/tb_bram_stream_master.sv
// Bench for bram_stream_master: BRAM behavioural model plus a queue-based response reference.
module tb_bram_stream_master;
  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned DEPTH  = 4;
`ifdef BRAM_STREAM_MASTER_WRRESP_EN
  localparam bit WRRESP = 1'b1;
`else
  localparam bit WRRESP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bram_stream_master_if #(.ADDR_BITW(AW), .DATA_BITW(DW)) bus ();

  bram_stream_master #(
    .ADDR_BITW(AW), .DATA_BITW(DW), .RD_LAT(RD_LAT), .RESP_DEPTH(DEPTH)
  ) dut (
    .Clk_CI(clk), .Rst_RBI(rst_n), .bus(bus)
  );

  // BRAM model: read-first, RD_LAT cycles of read latency, preload port for setup.
  logic [31:0] bram [64];
  logic [31:0] rd_pipe [RD_LAT];
  logic        pre_en;
  logic [5:0]  pre_idx;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    if (pre_en) begin
      bram[pre_idx] <= pre_data;
    end else if (bus.BramEn_SO) begin
      rd_pipe[0] <= bram[bus.BramAddr_DO[7:2]];
      for (int b = 0; b < 4; b++)
        if (bus.BramWrEn_DO[b]) bram[bus.BramAddr_DO[7:2]][8*b +: 8] <= bus.BramWrData_DO[8*b +: 8];
    end
  end
  assign bus.BramRdData_DI = rd_pipe[RD_LAT-1];

  // Reference: memory image, expected responses with due cycle, outstanding credit count.
  typedef struct { logic [31:0] data; logic wr; int due; } resp_t;
  resp_t       exp_q[$];
  logic [31:0] ref_mem [64];
  int          outstanding = 0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        exp_ready, exp_en, exp_valid, exp_wr;
  logic [31:0] exp_data;

  task automatic drive(input logic v, input logic [31:0] a, input logic [3:0] we,
                       input logic [31:0] wd, input logic rr);
    bus.ReqValid_SI  = v;
    bus.ReqAddr_DI   = a;
    bus.ReqWrEn_DI   = we;
    bus.ReqWrData_DI = wd;
    bus.RespReady_SI = rr;
  endtask

  task automatic eval();
    exp_ready = (outstanding < int'(DEPTH));
    exp_en    = bus.ReqValid_SI && exp_ready;
    exp_valid = (exp_q.size() != 0) && (exp_q[0].due <= cyc);
    exp_data  = exp_valid ? exp_q[0].data : 32'h0;
    exp_wr    = exp_valid ? exp_q[0].wr : 1'b0;
  endtask

  task automatic advance();
    logic acc, pop, wr;
    logic [31:0] a, wd, old;
    logic [3:0] we;
    acc = exp_en;
    pop = exp_valid && bus.RespReady_SI;
    a = bus.ReqAddr_DI; we = bus.ReqWrEn_DI; wd = bus.ReqWrData_DI; wr = |we;
    @(posedge clk);
    if (pop) begin exp_q.delete(0); outstanding--; end
    if (acc) begin
      old = ref_mem[a[7:2]];
      for (int b = 0; b < 4; b++) if (we[b]) ref_mem[a[7:2]][8*b +: 8] = wd[8*b +: 8];
      if (!wr || WRRESP) begin
        exp_q.push_back('{wr ? 32'h0 : old, wr, cyc + int'(RD_LAT) + 1});
        outstanding++;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b1, 32'h44, 4'hF, 32'hDEADBEEF, 1'b1);
    #1;
    checks++; if (bus.ReqReady_SO !== 1'b0) begin errors++; $display("FAIL rst_ready got %0b exp 0", bus.ReqReady_SO); end
    checks++; if (bus.RespValid_SO !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", bus.RespValid_SO); end
    checks++; if (bus.RespRdData_DO !== 32'h0) begin errors++; $display("FAIL rst_rdata got %0h exp 0", bus.RespRdData_DO); end
    checks++; if (bus.RespWasWr_SO !== 1'b0) begin errors++; $display("FAIL rst_waswr got %0b exp 0", bus.RespWasWr_SO); end
    checks++; if (bus.BramEn_SO !== 1'b0) begin errors++; $display("FAIL rst_en got %0b exp 0", bus.BramEn_SO); end
    checks++; if (bus.BramAddr_DO !== 32'h0) begin errors++; $display("FAIL rst_addr got %0h exp 0", bus.BramAddr_DO); end
    checks++; if (bus.BramWrEn_DO !== 4'h0) begin errors++; $display("FAIL rst_wren got %0h exp 0", bus.BramWrEn_DO); end
    checks++; if (bus.BramWrData_DO !== 32'h0) begin errors++; $display("FAIL rst_wdata got %0h exp 0", bus.BramWrData_DO); end
    checks++; if (bus.BramRst_RO !== 1'b1) begin errors++; $display("FAIL rst_bramrst got %0b exp 1", bus.BramRst_RO); end
    checks++; if (bus.BramClk_CO !== clk) begin errors++; $display("FAIL rst_bramclk got %0b exp %0b", bus.BramClk_CO, clk); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    #1;
    checks++; if (bus.ReqReady_SO !== 1'b1) begin errors++; $display("FAIL rel_ready got %0b exp 1", bus.ReqReady_SO); end
    checks++; if (bus.BramRst_RO !== 1'b0) begin errors++; $display("FAIL rel_bramrst got %0b exp 0", bus.BramRst_RO); end
    eval(); advance();
  endtask

  task automatic test_single_read();
    drive(1'b1, 32'h10, 4'h0, 32'h0, 1'b1);
    #1; eval();
    checks++; if (bus.BramEn_SO !== 1'b1) begin errors++; $display("FAIL sr_en got %0b exp 1", bus.BramEn_SO); end
    checks++; if (bus.BramAddr_DO !== 32'h10) begin errors++; $display("FAIL sr_addr got %0h exp 10", bus.BramAddr_DO); end
    advance();
    drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    for (int k = 1; k <= int'(RD_LAT) + 1; k++) begin
      #1; eval();
      checks++;
      if (bus.RespValid_SO !== (k == int'(RD_LAT) + 1)) begin
        errors++; $display("FAIL sr_latency cycle %0d got %0b exp %0b", k, bus.RespValid_SO, (k == int'(RD_LAT) + 1));
      end
      if (k == int'(RD_LAT) + 1) begin
        checks++; if (bus.RespRdData_DO !== 32'hCAFEF00D) begin errors++; $display("FAIL sr_data got %0h exp cafef00d", bus.RespRdData_DO); end
        checks++; if (bus.RespWasWr_SO !== 1'b0) begin errors++; $display("FAIL sr_waswr got %0b exp 0", bus.RespWasWr_SO); end
      end
      advance();
    end
  endtask

  task automatic test_write_read();
    int n = 0;
    int exp_n = WRRESP ? 2 : 1;
    logic [31:0] got_d [2];
    logic        got_w [2];
    drive(1'b1, 32'h20, 4'b0011, 32'hA5A5A5A5, 1'b1);
    #1; eval();
    checks++; if (bus.BramWrEn_DO !== 4'b0011) begin errors++; $display("FAIL wr_wren got %0h exp 3", bus.BramWrEn_DO); end
    checks++; if (bus.BramWrData_DO !== 32'hA5A5A5A5) begin errors++; $display("FAIL wr_wdata got %0h exp a5a5a5a5", bus.BramWrData_DO); end
    advance();
    drive(1'b1, 32'h20, 4'h0, 32'h0, 1'b1);
    #1; eval();
    checks++; if (bus.BramWrEn_DO !== 4'h0) begin errors++; $display("FAIL wrrd_wren got %0h exp 0", bus.BramWrEn_DO); end
    advance();
    drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      #1; eval();
      if (bus.RespValid_SO === 1'b1) begin
        if (n < 2) begin got_d[n] = bus.RespRdData_DO; got_w[n] = bus.RespWasWr_SO; end
        n++;
      end
      advance();
    end
    checks++; if (n !== exp_n) begin errors++; $display("FAIL wrrd_count got %0d exp %0d", n, exp_n); end
    checks++; if (got_d[exp_n-1] !== 32'h1122A5A5) begin errors++; $display("FAIL wrrd_rdata got %0h exp 1122a5a5", got_d[exp_n-1]); end
    checks++; if (got_w[exp_n-1] !== 1'b0) begin errors++; $display("FAIL wrrd_rd_waswr got %0b exp 0", got_w[exp_n-1]); end
`ifdef BRAM_STREAM_MASTER_WRRESP_EN
    checks++; if (got_w[0] !== 1'b1) begin errors++; $display("FAIL wrrd_wr_waswr got %0b exp 1", got_w[0]); end
    checks++; if (got_d[0] !== 32'h0) begin errors++; $display("FAIL wrrd_wr_data got %0h exp 0", got_d[0]); end
`endif
  endtask

  task automatic test_backpressure();
    int acc_n = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h40 + 32'(4*i), 4'h0, 32'h0, 1'b0);
      #1; eval();
      if (bus.BramEn_SO === 1'b1) acc_n++;
      checks++; if (bus.BramEn_SO !== exp_en) begin errors++; $display("FAIL bp_en cycle %0d got %0b exp %0b", i, bus.BramEn_SO, exp_en); end
      advance();
    end
    drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    #1;
    checks++; if (acc_n !== int'(DEPTH)) begin errors++; $display("FAIL bp_accepts got %0d exp %0d", acc_n, DEPTH); end
    checks++; if (bus.ReqReady_SO !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %0b exp 0", bus.ReqReady_SO); end
    checks++; if (bus.RespValid_SO !== 1'b1) begin errors++; $display("FAIL bp_valid got %0b exp 1", bus.RespValid_SO); end
    drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    #1; eval();
    checks++; if (bus.ReqReady_SO !== 1'b0) begin errors++; $display("FAIL bp_pop_ready got %0b exp 0", bus.ReqReady_SO); end
    advance();
    drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    #1; eval();
    checks++; if (bus.ReqReady_SO !== 1'b1) begin errors++; $display("FAIL bp_reopen got %0b exp 1", bus.ReqReady_SO); end
    checks++; if (int'(dut.cnt) !== int'(DEPTH) - 1) begin errors++; $display("FAIL bp_cnt got %0d exp %0d", dut.cnt, DEPTH - 1); end
    advance();
  endtask

  task automatic test_streaming();
    int t0, first = -1, resp_n = 0;
    for (int k = 0; k < 32 && exp_q.size() != 0; k++) begin
      drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
      #1; eval();
      checks++; if (bus.RespRdData_DO !== exp_data) begin errors++; $display("FAIL drain_data got %0h exp %0h", bus.RespRdData_DO, exp_data); end
      advance();
    end
    t0 = cyc;
    for (int k = 0; k < 40 && (k < 16 || exp_q.size() != 0); k++) begin
      drive(k < 16, 32'(4*k), 4'h0, 32'h0, 1'b1);
      #1; eval();
      if (k < 16) begin
        checks++; if (bus.BramEn_SO !== 1'b1) begin errors++; $display("FAIL st_accept %0d got %0b exp 1", k, bus.BramEn_SO); end
        checks++; if (bus.BramAddr_DO !== 32'(4*k)) begin errors++; $display("FAIL st_addr got %0h exp %0h", bus.BramAddr_DO, 4*k); end
      end
      checks++; if (bus.RespValid_SO !== exp_valid) begin errors++; $display("FAIL st_valid got %0b exp %0b", bus.RespValid_SO, exp_valid); end
      if (exp_valid) begin
        checks++; if (bus.RespRdData_DO !== exp_data) begin errors++; $display("FAIL st_data got %0h exp %0h", bus.RespRdData_DO, exp_data); end
      end
      if (bus.RespValid_SO === 1'b1) begin
        resp_n++;
        if (first < 0) first = cyc;
      end
      advance();
    end
    checks++; if (first !== t0 + int'(RD_LAT) + 1) begin errors++; $display("FAIL st_first got %0d exp %0d", first - t0, RD_LAT + 1); end
    checks++; if (resp_n !== 16) begin errors++; $display("FAIL st_count got %0d exp 16", resp_n); end
  endtask

  task automatic test_random();
    int sent = 0;
    logic v, rr;
    logic [31:0] a, wd;
    logic [3:0] we;
    for (int k = 0; k < 3000 && (sent < 100 || exp_q.size() != 0); k++) begin
      v  = (sent < 100) && ($urandom_range(3) != 0);
      a  = {24'h0, 6'($urandom_range(63)), 2'b00};
      we = ($urandom_range(1) == 1) ? 4'($urandom) : 4'h0;
      wd = $urandom;
      rr = ($urandom_range(3) != 0);
      drive(v, a, we, wd, rr);
      #1; eval();
      checks++; if (bus.ReqReady_SO !== exp_ready) begin errors++; $display("FAIL rnd_ready got %0b exp %0b", bus.ReqReady_SO, exp_ready); end
      checks++; if (bus.BramEn_SO !== exp_en) begin errors++; $display("FAIL rnd_en got %0b exp %0b", bus.BramEn_SO, exp_en); end
      checks++; if (bus.RespValid_SO !== exp_valid) begin errors++; $display("FAIL rnd_valid got %0b exp %0b", bus.RespValid_SO, exp_valid); end
      checks++; if (int'(dut.cnt) !== outstanding) begin errors++; $display("FAIL rnd_cnt got %0d exp %0d", dut.cnt, outstanding); end
      if (exp_valid) begin
        checks++; if (bus.RespRdData_DO !== exp_data) begin errors++; $display("FAIL rnd_data got %0h exp %0h", bus.RespRdData_DO, exp_data); end
        checks++; if (bus.RespWasWr_SO !== exp_wr) begin errors++; $display("FAIL rnd_waswr got %0b exp %0b", bus.RespWasWr_SO, exp_wr); end
      end
      if (exp_en) begin
        sent++;
        checks++; if (bus.BramAddr_DO !== a) begin errors++; $display("FAIL rnd_addr got %0h exp %0h", bus.BramAddr_DO, a); end
      end
      advance();
    end
    drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    #1;
    checks++; if (bus.RespValid_SO !== 1'b0) begin errors++; $display("FAIL rnd_drained got %0b exp 0", bus.RespValid_SO); end
    checks++; if (bus.ReqReady_SO !== 1'b1) begin errors++; $display("FAIL rnd_idle_ready got %0b exp 1", bus.ReqReady_SO); end
    eval(); advance();
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 3 + int'(RD_LAT) + 1; i++) begin
      drive(i < 3, 32'(4*i), 4'h0, 32'h0, 1'b0);
      #1; eval(); advance();
    end
    drive(1'b1, 32'h8, 4'h0, 32'h0, 1'b0);
    #1;
    checks++; if (bus.RespValid_SO !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %0b exp 1", bus.RespValid_SO); end
    checks++; if (int'(dut.cnt) !== 3) begin errors++; $display("FAIL mid_pre_cnt got %0d exp 3", dut.cnt); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.RespValid_SO !== 1'b0) begin errors++; $display("FAIL mid_valid got %0b exp 0", bus.RespValid_SO); end
    checks++; if (bus.BramEn_SO !== 1'b0) begin errors++; $display("FAIL mid_en got %0b exp 0", bus.BramEn_SO); end
    checks++; if (bus.BramAddr_DO !== 32'h0) begin errors++; $display("FAIL mid_addr got %0h exp 0", bus.BramAddr_DO); end
    checks++; if (bus.BramRst_RO !== 1'b1) begin errors++; $display("FAIL mid_bramrst got %0b exp 1", bus.BramRst_RO); end
    exp_q.delete();
    outstanding = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    #1;
    checks++; if (bus.ReqReady_SO !== 1'b1) begin errors++; $display("FAIL mid_rel_ready got %0b exp 1", bus.ReqReady_SO); end
    for (int k = 0; k < 6; k++) begin
      #1; eval();
      checks++; if (bus.RespValid_SO !== 1'b0) begin errors++; $display("FAIL mid_stale cycle %0d got %0b exp 0", k, bus.RespValid_SO); end
      advance();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pre_en = 1'b0;
    drive(1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      pre_en   = 1'b1;
      pre_idx  = 6'(i);
      pre_data = (i == 4) ? 32'hCAFEF00D : (i == 8) ? 32'h11223344 : $urandom;
      ref_mem[i] = pre_data;
    end
    @(negedge clk);
    pre_en = 1'b0;
    test_reset();
    test_single_read();
    test_write_read();
    test_backpressure();
    test_streaming();
    test_random();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bram_stream_master.md
# bram_stream_master

Converts a valid/ready request stream into BRAM-port master accesses and returns in-order responses over a valid/ready response stream. Sits directly upstream of the BRAM data-width converter: its BRAM-side ports drive the converter's narrow slave port, or a BRAM directly. Credit-based flow control guarantees that every issued access has a response-buffer slot, so the BRAM side never stalls.

## Interface
- ADDR_BITW, 32, byte address width
- DATA_BITW, 32, data width; multiple of 8
- RD_LAT, 1, BRAM read latency in cycles, 1..4
- RESP_DEPTH, 4, response FIFO entries; power of two, >= 2

- Clk_CI  in  1  clock
- Rst_RBI  in  1  reset, asynchronous, active-low
- ReqValid_SI  in  1  request valid
- ReqReady_SO  out  1  request ready
- ReqAddr_DI  in  ADDR_BITW  byte address
- ReqWrEn_DI  in  DATA_BITW/8  byte write strobes; all-zero means read
- ReqWrData_DI  in  DATA_BITW  write data
- RespValid_SO  out  1  response valid
- RespReady_SI  in  1  response ready
- RespRdData_DO  out  DATA_BITW  read data; 0 for write responses
- RespWasWr_SO  out  1  response belongs to a write
- BramClk_CO  out  1  equals Clk_CI
- BramRst_RO  out  1  active-high, equals ~Rst_RBI
- BramEn_SO  out  1  BRAM enable
- BramAddr_DO  out  ADDR_BITW  BRAM address
- BramWrEn_DO  out  DATA_BITW/8  BRAM byte write enables
- BramWrData_DO  out  DATA_BITW  BRAM write data
- BramRdData_DI  in  DATA_BITW  BRAM read data

## Operation
- Accept: a request is accepted when ReqValid_SI && ReqReady_SO. BramEn_SO equals the accept condition, combinationally.
- BRAM outputs: in the accept cycle, BramAddr/WrEn/WrData pass ReqAddr/WrEn/WrData through. Otherwise all three are 0.
- Tag pipeline: an RD_LAT-stage shift register carries {valid, isWr} for each accepted request.
- Capture: at stage RD_LAT exit, the FIFO pushes {BramRdData_DI, isWr}. Rd data is forced to 0 when isWr=1.
- Credit counter Cnt_SP (width $clog2(RESP_DEPTH)+1) counts in-flight tags plus FIFO occupancy.
  - +1 on accept; -1 on response handshake (RespValid_SO && RespReady_SI).
  - Both in one cycle: Cnt_SP unchanged.
- ReqReady_SO = Cnt_SP < RESP_DEPTH, a function of registered state only. A pop in the same cycle does not raise ReqReady_SO; that is a one-cycle bubble at full.
- Overflow impossible: the FIFO cannot overflow and the BRAM pipeline never stalls.
- Ordering: responses are strictly in request order; reads and writes are never reordered.
- Response outputs: RespValid_SO = FIFO not empty. RespRdData_DO/RespWasWr_SO show the FIFO head and stay stable while RespValid_SO && !RespReady_SI.
- FIFO: circular buffer with read/write pointers that wrap modulo RESP_DEPTH. Simultaneous push and pop is legal at any occupancy, including empty (push-through is not combinational) and full.

## Timing
- Reset values (Rst_RBI low): ReqReady_SO=0, RespValid_SO=0, RespRdData_DO=0, RespWasWr_SO=0, BramEn_SO=0, BramAddr/WrEn/WrData=0, BramRst_RO=1. Cnt_SP, pointers and tags are cleared.
- First cycle after reset release: ReqReady_SO=1.
- Response latency: request accepted in cycle t gives RespValid_SO high in cycle t+RD_LAT+1.
  - Minimum is 2 cycles (RD_LAT=1).
- Throughput: one request per cycle while RespReady_SI=1 and Cnt_SP < RESP_DEPTH. Sustained full throughput requires RESP_DEPTH >= RD_LAT+2.
- Reset mid-operation: in-flight and buffered responses are discarded with no response emitted. BRAM outputs drop to 0 asynchronously.

## Configuration
- BRAM_STREAM_MASTER_WRRESP_EN defined: behaviour as above; every write produces a response with RespWasWr_SO=1.
- Undefined: writes produce no response and consume no credit (no Cnt_SP increment, no tag valid). Only reads push the FIFO, and RespWasWr_SO is tied to 0.

## Test plan
- Single read: RD_LAT=1, BRAM word 0x10 preloaded with 0xCAFEF00D. Read accepted at t -> BramEn_SO=1, BramAddr_DO=0x10 at t; RespValid_SO=1 with 0xCAFEF00D at t+2.
- Write then read: write 0xA5A5A5A5 with strobes 4'b0011 to 0x20 (old value 0x11223344), then read 0x20. With WRRESP_EN, the write response comes first (RespWasWr_SO=1, data 0), then the read returns 0x1122A5A5.
- Back-pressure: RESP_DEPTH=4, RespReady_SI=0, ReqValid_SI=1 reads -> exactly 4 accepted, then ReqReady_SO=0. Raising RespReady_SI for 1 cycle pops 1 and ReqReady_SO returns high the next cycle.
- Streaming: RD_LAT=2, RESP_DEPTH=4, 16 back-to-back reads of addresses 0x0..0x3C, RespReady_SI=1 -> 16 accepts in 16 consecutive cycles; responses in order, first at t+3.
- Wrap and simultaneity: 100 random read/write requests with random RespReady_SI -> responses match a reference queue, and Cnt_SP equals outstanding count every cycle.
- Reset mid-op: Rst_RBI low with 3 responses buffered -> RespValid_SO=0 immediately; after release, no stale responses and ReqReady_SO=1.
